board_store_arbiter: RTL and testbench
======================================

Name: board_store_arbiter

Overview:
Owns the 64-square registered chess board and presents it flat to the game logic and renderer. After reset, or on request, it sequences a 64-cycle load of the starting position. In the RUN state it arbitrates the single board write port. The game-logic mover has absolute priority. An auxiliary requester (setup/undo unit) uses a req/grant handshake.

Parameters:
CLEAR_ONLY, 0, 1 = the init sequence writes EMPTY (4'h0) to every square instead of the start position
PLY_WIDTH, 10, width of the optional ply counter

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; asynchronous, active-high
init_req  in  1  single-cycle pulse; restart the board load
gl_en  in  1  game-logic write strobe
gl_addr  in  6  game-logic write square, {row[2:0], col[2:0]}
gl_piece  in  4  game-logic write value, {colour, type}
aux_req  in  1  auxiliary write request; held until granted
aux_addr  in  6  auxiliary write square
aux_piece  in  4  auxiliary write value
aux_gnt  out  1  combinational grant; the write commits on this edge
board_flat  out  256  square n at bits [4n+3:4n]
init_done  out  1  high in RUN
gl_drop  out  1  sticky: a game-logic write was discarded
ply_count  out  PLY_WIDTH  completed plies (see Optional Feature)

Behaviour:
- Encoding: colour bit3 (0 white, 1 black); type EMPTY 0, PAWN 1, BISHOP 2, KNIGHT 3, ROOK 4, QUEEN 5, KING 6.
- Reset values: board_flat = 0, state = INIT, init counter = 0, init_done = 0, gl_drop = 0, ply_count = 0.
- State INIT:
  - Each edge writes square cnt and increments cnt.
  - The edge that writes square 63 moves to RUN. init_done rises 64 edges after reset release.
- Start position:
  - Row 0 = black R N B Q K B N R: 4'hC, 4'hB, 4'hA, 4'hD, 4'hE, 4'hA, 4'hB, 4'hC.
  - Row 1 = 4'h9 on every square.
  - Rows 2-5 = 4'h0.
  - Row 6 = 4'h1 on every square.
  - Row 7 = white 4'h4, 4'h3, 4'h2, 4'h5, 4'h6, 4'h2, 4'h3, 4'h4.
- In INIT:
  - aux_gnt = 0.
  - gl_en is discarded and sets gl_drop.
  - init_req restarts cnt at 0.
- State RUN:
  - Priority order: init_req > gl_en > aux_req.
  - init_req: go to INIT with cnt = 0 and clear gl_drop. If gl_en is high in the same cycle, that write is discarded and gl_drop is set (set wins over clear).
  - gl_en: board[gl_addr] <= gl_piece on this edge; aux_gnt = 0.
  - aux_gnt = aux_req & ~gl_en & ~init_req; the granted write commits on that edge.
  - A starved requester keeps aux_req high; there is no timeout.
- Write latency: a write is visible on board_flat the cycle after its edge. No read-modify-write; the other 63 squares are untouched.
- Simultaneous gl and aux writes to the same square: only gl is applied (aux is not granted).
- Reset mid-INIT or mid-RUN: immediately returns to the reset values above.

Optional Feature:
- Macro: BOARD_PLY_COUNT_EN.
- Defined: ply_count increments, saturating at all-ones, on each accepted gl write whose gl_piece[2:0] == EMPTY (the erase half of a move). It clears on reset and when INIT is entered via init_req.
- Undefined: ply_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset release, wait 64 cycles:
  - init_done rises exactly on edge 64.
  - board_flat[3:0] = 4'hC, [19:16] = 4'hE, [227:224] = 4'h4, [243:240] = 4'h6.
  - Bits [191:64] are all 0.
- In RUN:
  - Cycle 1: gl_en with addr 52, piece 4'h1.
  - Cycle 2: gl_en with addr 36, piece 4'h1; then gl_en with addr 52, piece 4'h0.
  - Result: square 36 = 1, square 52 = 0; ply_count = 1 when the macro is defined, 0 otherwise.
- aux_req held high with addr 0, piece 4'h0 while gl_en is high for 3 cycles:
  - aux_gnt stays 0 for those 3 cycles.
  - aux_gnt goes 1 on the 4th cycle; square 0 = 0 on the next cycle.
- gl_en pulsed at cycle 10 of INIT:
  - gl_drop = 1 and the target square holds its start value.
  - A subsequent init_req with gl_en low clears gl_drop.
- init_req in RUN after edits:
  - init_done drops next cycle; the board is restored after 64 cycles.
  - A second init_req at INIT cycle 30 delays init_done by 30 more cycles.
- CLEAR_ONLY = 1: after init, board_flat = 0.
- Async rst at INIT cycle 20: the board returns to 0 and the full 64-cycle load is redone.

Source files
------------

// File: rtl/board_store_arbiter.sv
// -----------------------------------------------------------------------------
// board_store_arbiter
//
// Owns the 64-square registered chess board and presents it flat to the game
// logic and the renderer. After reset, or on init_req, it loads the starting
// position one square per clock (64 clocks). In RUN it arbitrates the single
// board write port between the game-logic mover (absolute priority) and an
// auxiliary setup/undo requester that uses a req/grant handshake.
//
// Parameters:
//   CLEAR_ONLY  1 = the load sequence writes EMPTY to every square
//   PLY_WIDTH   width of the ply counter output
//
// Optional feature (macro BOARD_PLY_COUNT_EN):
//   defined   -> ply_count counts accepted game-logic erase writes (saturating)
//   undefined -> ply_count is tied to zero
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   init_req              single-cycle pulse, restart the board load
//   gl_en/addr/piece      game-logic write port (square {row,col}, {colour,type})
//   aux_req/addr/piece    auxiliary write request, held until granted
//   aux_gnt               combinational grant; the write commits on this edge
//   board_flat            square n at bits [4n+3:4n]
//   init_done             high while in RUN
//   gl_drop               sticky: a game-logic write was discarded
//   ply_count             completed plies
// -----------------------------------------------------------------------------
module board_store_arbiter #(
    parameter bit CLEAR_ONLY = 1'b0,
    parameter int PLY_WIDTH  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_req,
    input  logic                 gl_en,
    input  logic [5:0]           gl_addr,
    input  logic [3:0]           gl_piece,
    input  logic                 aux_req,
    input  logic [5:0]           aux_addr,
    input  logic [3:0]           aux_piece,
    output logic                 aux_gnt,
    output logic [255:0]         board_flat,
    output logic                 init_done,
    output logic                 gl_drop,
    output logic [PLY_WIDTH-1:0] ply_count
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [5:0]       r_cnt;
    logic [5:0]       w_cnt_next;
    logic [63:0][3:0] r_board;
    logic             r_gl_drop;

    logic             w_we;
    logic [5:0]       w_waddr;
    logic [3:0]       w_wdata;
    logic             w_drop_set;
    logic             w_restart;

    // Piece type on the back rank by column: R N B Q K B N R.
    function automatic logic [2:0] back_rank_type(input logic [2:0] col);
        logic [2:0] t;
        case (col)
            3'd0, 3'd7: t = 3'd4;
            3'd1, 3'd6: t = 3'd3;
            3'd2, 3'd5: t = 3'd2;
            3'd3:       t = 3'd5;
            default:    t = 3'd6;
        endcase
        return t;
    endfunction

    // Value written to a square during the load sequence.
    function automatic logic [3:0] start_piece(input logic [5:0] sq);
        logic [3:0] v;
        v = 4'h0;
        if (!CLEAR_ONLY) begin
            case (sq[5:3])
                3'd0:    v = {1'b1, back_rank_type(sq[2:0])};
                3'd1:    v = 4'h9;
                3'd6:    v = 4'h1;
                3'd7:    v = {1'b0, back_rank_type(sq[2:0])};
                default: v = 4'h0;
            endcase
        end
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state and write-port arbitration.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        aux_gnt      = 1'b0;
        w_we         = 1'b0;
        w_waddr      = r_cnt;
        w_wdata      = start_piece(r_cnt);
        w_drop_set   = 1'b0;
        w_restart    = 1'b0;

        case (r_state)
            ST_INIT: begin
                // The load owns the write port; any game-logic write is lost.
                w_we       = 1'b1;
                w_drop_set = gl_en;
                if (init_req) begin
                    w_cnt_next = 6'd0;
                end else begin
                    w_cnt_next = r_cnt + 6'd1;
                    if (r_cnt == 6'd63) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    w_state_next = ST_INIT;
                    w_cnt_next   = 6'd0;
                    w_restart    = 1'b1;
                    w_drop_set   = gl_en;
                end else if (gl_en) begin
                    w_we    = 1'b1;
                    w_waddr = gl_addr;
                    w_wdata = gl_piece;
                end else if (aux_req) begin
                    aux_gnt = 1'b1;
                    w_we    = 1'b1;
                    w_waddr = aux_addr;
                    w_wdata = aux_piece;
                end
            end
            default: begin
                w_state_next = ST_INIT;
                w_cnt_next   = 6'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: the board is flops, not RAM, and must read as all-EMPTY straight
    // out of reset, so every square is reset explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_board <= '0;
        end else if (w_we) begin
            r_board[w_waddr] <= w_wdata;
        end
    end

    // A discard in the same cycle as a restart must survive the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gl_drop <= 1'b0;
        end else if (w_drop_set) begin
            r_gl_drop <= 1'b1;
        end else if (w_restart) begin
            r_gl_drop <= 1'b0;
        end
    end

`ifdef BOARD_PLY_COUNT_EN
    logic [PLY_WIDTH-1:0] r_ply;
    logic                 w_ply_inc;

    // An accepted game-logic write of an EMPTY type is the erase half of a move.
    assign w_ply_inc = (r_state == ST_RUN) && !init_req && gl_en &&
                       (gl_piece[2:0] == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ply <= '0;
        end else if (w_restart) begin
            r_ply <= '0;
        end else if (w_ply_inc && (r_ply != '1)) begin
            r_ply <= r_ply + 1'b1;
        end
    end

    assign ply_count = r_ply;
`else
    assign ply_count = '0;
`endif

    assign board_flat = r_board;
    assign init_done  = (r_state == ST_RUN);
    assign gl_drop    = r_gl_drop;

endmodule

// File: tb/tb_board_store_arbiter.sv
module tb_board_store_arbiter;

    localparam int PLY_WIDTH = 10;
`ifdef BOARD_PLY_COUNT_EN
    localparam bit PLY_ON = 1'b1;
`else
    localparam bit PLY_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 init_req;
    logic                 gl_en;
    logic [5:0]           gl_addr;
    logic [3:0]           gl_piece;
    logic                 aux_req;
    logic [5:0]           aux_addr;
    logic [3:0]           aux_piece;
    logic                 aux_gnt;
    logic [255:0]         board_flat;
    logic                 init_done;
    logic                 gl_drop;
    logic [PLY_WIDTH-1:0] ply_count;

    logic                 c_gnt;
    logic [255:0]         c_board;
    logic                 c_done;
    logic                 c_drop;
    logic [PLY_WIDTH-1:0] c_ply;

    int total = 0;
    int bad   = 0;

    // Behavioural reference: the board as an array of squares plus the
    // load progress (how far the load has got, and whether it has finished).
    logic [3:0] m_board [64];
    int         m_next_sq;
    bit         m_run;
    bit         m_drop;
    int         m_ply;
    bit         m_gnt;
    logic       obs_gnt;
    int         back [8];

    always #5 clk = ~clk;

    board_store_arbiter #(.CLEAR_ONLY(1'b0), .PLY_WIDTH(PLY_WIDTH)) u_dut (
        .clk(clk), .rst(rst), .init_req(init_req),
        .gl_en(gl_en), .gl_addr(gl_addr), .gl_piece(gl_piece),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_piece(aux_piece),
        .aux_gnt(aux_gnt), .board_flat(board_flat), .init_done(init_done),
        .gl_drop(gl_drop), .ply_count(ply_count)
    );

    board_store_arbiter #(.CLEAR_ONLY(1'b1), .PLY_WIDTH(PLY_WIDTH)) u_clr (
        .clk(clk), .rst(rst), .init_req(1'b0),
        .gl_en(1'b0), .gl_addr(6'd0), .gl_piece(4'd0),
        .aux_req(1'b0), .aux_addr(6'd0), .aux_piece(4'd0),
        .aux_gnt(c_gnt), .board_flat(c_board), .init_done(c_done),
        .gl_drop(c_drop), .ply_count(c_ply)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] start_val(input int sq);
        int row;
        int col;
        row = sq / 8;
        col = sq % 8;
        if (row == 0) return 4'(8 + back[col]);
        if (row == 1) return 4'h9;
        if (row == 6) return 4'h1;
        if (row == 7) return 4'(back[col]);
        return 4'h0;
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 64; i++) f[4*i +: 4] = m_board[i];
        return f;
    endfunction

    function automatic logic [255:0] start_flat();
        logic [255:0] f;
        for (int i = 0; i < 64; i++) f[4*i +: 4] = start_val(i);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_board[i] = 4'h0;
        m_next_sq = 0;
        m_run     = 1'b0;
        m_drop    = 1'b0;
        m_ply     = 0;
        m_gnt     = 1'b0;
    endtask

    // Apply the rules for one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (!m_run) begin
            if (gl_en) m_drop = 1'b1;
            m_board[m_next_sq] = start_val(m_next_sq);
            if (init_req) m_next_sq = 0;
            else if (m_next_sq == 63) begin
                m_run     = 1'b1;
                m_next_sq = 0;
            end else m_next_sq++;
        end else if (init_req) begin
            m_run     = 1'b0;
            m_next_sq = 0;
            m_drop    = gl_en;
            m_ply     = 0;
        end else if (gl_en) begin
            m_board[gl_addr] = gl_piece;
            if (gl_piece[2:0] == 3'd0 && m_ply < (1 << PLY_WIDTH) - 1) m_ply++;
        end else if (aux_req) begin
            m_board[aux_addr] = aux_piece;
        end
    endtask

    // One clock: check the combinational grant mid-cycle, step the model on
    // the edge, then check the registered outputs 1 time unit later.
    task automatic tick(input string tag);
        logic exp_gnt;
        #1;
        exp_gnt = m_run && aux_req && !gl_en && !init_req;
        obs_gnt = aux_gnt;
        check($sformatf("%s/gnt", tag), 256'(aux_gnt), 256'(exp_gnt));
        @(posedge clk);
        m_gnt = exp_gnt;
        model_edge();
        #1;
        check($sformatf("%s/board", tag), board_flat, model_flat());
        check($sformatf("%s/done", tag), 256'(init_done), 256'(m_run));
        check($sformatf("%s/drop", tag), 256'(gl_drop), 256'(m_drop));
        check($sformatf("%s/ply", tag), 256'(ply_count), PLY_ON ? 256'(m_ply) : 256'd0);
    endtask

    initial begin
        back = '{4, 3, 2, 5, 6, 2, 3, 4};
        rst = 1'b1;
        init_req = 1'b0; gl_en = 1'b0; gl_addr = 6'd0; gl_piece = 4'd0;
        aux_req = 1'b0; aux_addr = 6'd0; aux_piece = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst/board", board_flat, 256'd0);
        check("rst/done", 256'(init_done), 256'd0);
        check("rst/drop", 256'(gl_drop), 256'd0);
        check("rst/ply", 256'(ply_count), 256'd0);
        rst = 1'b0;

        // Initial load: init_done must rise on exactly the 64th edge.
        for (int i = 1; i <= 64; i++) begin
            tick("load");
            if (i == 63) check("load63/done", 256'(init_done), 256'd0);
            if (i == 64) check("load64/done", 256'(init_done), 256'd1);
        end
        check("load/sq0", 256'(board_flat[3:0]), 256'h0C);
        check("load/sq4", 256'(board_flat[19:16]), 256'h0E);
        check("load/sq56", 256'(board_flat[227:224]), 256'h04);
        check("load/sq60", 256'(board_flat[243:240]), 256'h06);
        check("load/mid", 256'(board_flat[191:64]), 256'd0);
        check("clr/board", c_board, 256'd0);
        check("clr/done", 256'(c_done), 256'd1);

        // Game-logic moves: pawn 52 -> 36, erasing 52.
        gl_en = 1'b1; gl_addr = 6'd52; gl_piece = 4'h1; tick("gl1");
        gl_addr = 6'd36; gl_piece = 4'h1; tick("gl2");
        gl_addr = 6'd52; gl_piece = 4'h0; tick("gl3");
        gl_en = 1'b0;
        check("mv/sq36", 256'(board_flat[147:144]), 256'h1);
        check("mv/sq52", 256'(board_flat[211:208]), 256'h0);
        check("mv/ply", 256'(ply_count), PLY_ON ? 256'd1 : 256'd0);

        // Aux starved by gl for three cycles, same target square.
        aux_req = 1'b1; aux_addr = 6'd0; aux_piece = 4'h0;
        gl_en = 1'b1; gl_addr = 6'd0; gl_piece = 4'h5;
        for (int i = 0; i < 3; i++) begin
            tick("glhold");
            check("aux_wait", 256'(obs_gnt), 256'd0);
            check("aux_sq0_gl", 256'(board_flat[3:0]), 256'h5);
        end
        gl_en = 1'b0;
        tick("auxgo");
        check("aux_gnt4", 256'(obs_gnt), 256'd1);
        check("aux_sq0", 256'(board_flat[3:0]), 256'h0);
        aux_req = 1'b0;

        // Restart from RUN, discarded gl at INIT cycle 10, second restart at 30.
        init_req = 1'b1; tick("reinit"); init_req = 1'b0;
        check("reinit/done", 256'(init_done), 256'd0);
        repeat (10) tick("ld_a");
        gl_en = 1'b1; gl_addr = 6'd5; gl_piece = 4'h0; tick("ld_gl"); gl_en = 1'b0;
        check("ld_gl/drop", 256'(gl_drop), 256'd1);
        repeat (19) tick("ld_b");
        init_req = 1'b1; tick("ld_re"); init_req = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick("ld_c");
            if (k == 63) check("ld63/done", 256'(init_done), 256'd0);
            if (k == 64) check("ld64/done", 256'(init_done), 256'd1);
        end
        check("ld/sq5", 256'(board_flat[23:20]), 256'hA);
        init_req = 1'b1; tick("clrdrop"); init_req = 1'b0;
        check("clrdrop/drop", 256'(gl_drop), 256'd0);
        repeat (64) tick("ld_d");
        check("restore", board_flat, start_flat());

        // init_req and gl_en together in RUN: the discard wins over the clear.
        init_req = 1'b1; gl_en = 1'b1; gl_addr = 6'd9; gl_piece = 4'h3;
        tick("both"); init_req = 1'b0; gl_en = 1'b0;
        check("both/drop", 256'(gl_drop), 256'd1);
        repeat (20) tick("pre_rst");

        // Asynchronous reset mid-load, no clock edge needed.
        rst = 1'b1;
        #2;
        check("arst/board", board_flat, 256'd0);
        check("arst/done", 256'(init_done), 256'd0);
        check("arst/drop", 256'(gl_drop), 256'd0);
        check("arst/clr", c_board, 256'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick("reload");
            if (k == 63) check("rl63/done", 256'(init_done), 256'd0);
            if (k == 64) check("rl64/done", 256'(init_done), 256'd1);
        end
        check("reload/board", board_flat, start_flat());

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            init_req = ($urandom_range(99) == 0);
            gl_en    = ($urandom_range(2) == 0);
            gl_addr  = 6'($urandom_range(63));
            gl_piece = 4'($urandom_range(15));
            if (!aux_req || m_gnt) begin
                aux_req   = ($urandom_range(1) == 1);
                aux_addr  = 6'($urandom_range(63));
                aux_piece = 4'($urandom_range(15));
            end
            tick("rand");
        end
        init_req = 1'b0; gl_en = 1'b0; aux_req = 1'b0;
        check("end/clr", c_board, 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
